gf2_mat_encoder: RTL



---
 rtl/gf2enc_pkg.sv | 25 ++
 rtl/gf2_row_bank.sv | 32 +++
 rtl/gf2_mat_encoder.sv | 98 +++++++++
 3 files changed

// File: rtl/gf2enc_pkg.sv
// Shared definitions for the GF(2) matrix encoder: state encodings,
// default dimensions and the identity-row helper used at reset.
package gf2enc_pkg;

    localparam int N_DEFAULT = 8;
    localparam int M_DEFAULT = 8;
    localparam int ROW_MAX_W = 64;

    typedef logic [1:0] state_t;

    localparam state_t IDLE = 2'd0;
    localparam state_t RUN  = 2'd1;
    localparam state_t DONE = 2'd2;

    // Row i of an identity generator; rows beyond min(n, m) are all-zero.
    function automatic logic [ROW_MAX_W-1:0] identity_row(input int i, input int n, input int m);
        logic [ROW_MAX_W-1:0] one;
        one = {{(ROW_MAX_W-1){1'b0}}, 1'b1};
        if (i < n && i < m && i < ROW_MAX_W)
            identity_row = one << i;
        else
            identity_row = '0;
    endfunction

endpackage

// File: rtl/gf2_row_bank.sv
// N x M generator-row register file: resets to identity, one write port,
// combinational read of the row selected by the encoder's index.
module gf2_row_bank
    import gf2enc_pkg::*;
#(
    parameter int N = N_DEFAULT,
    parameter int M = M_DEFAULT
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 we,
    input  logic [$clog2(N)-1:0] wr_row,
    input  logic [M-1:0]         wr_data,
    input  logic [$clog2(N)-1:0] rd_row,
    output logic [M-1:0]         rd_data
);

    logic [M-1:0] rows [N];

    // Out-of-range row indices are silently dropped.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N; i++)
                rows[i] <= M'(identity_row(i, N, M));
        end else if (we && int'(wr_row) < N) begin
            rows[wr_row] <= wr_data;
        end
    end

    assign rd_data = rows[rd_row];

endmodule

// File: rtl/gf2_mat_encoder.sv
// Sequential GF(2) encoder: XORs one selected generator row per clock.
// Optional macro GF2ENC_PARITY_EN adds out_par = XOR-reduce of out_code.
module gf2_mat_encoder
    import gf2enc_pkg::*;
#(
    parameter int N = N_DEFAULT,
    parameter int M = M_DEFAULT
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [N-1:0]         in_msg,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [M-1:0]         out_code,
    input  logic                 cfg_we,
    input  logic [$clog2(N)-1:0] cfg_row,
    input  logic [M-1:0]         cfg_data,
    output logic                 busy
`ifdef GF2ENC_PARITY_EN
    ,
    output logic                 out_par
`endif
);

    localparam int IW = $clog2(N);

    state_t          state;
    logic [N-1:0]    msg;
    logic [M-1:0]    acc;
    logic [IW-1:0]   idx;
    logic [M-1:0]    row_data;
    logic [M-1:0]    acc_next;

    // Rows are only writable while idle so a running encode sees a fixed matrix.
    gf2_row_bank #(.N(N), .M(M)) u_bank (
        .clk     (clk),
        .rst_n   (rst_n),
        .we      (cfg_we && (state == IDLE)),
        .wr_row  (cfg_row),
        .wr_data (cfg_data),
        .rd_row  (idx),
        .rd_data (row_data)
    );

    assign acc_next  = acc ^ (msg[idx] ? row_data : '0);
    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign busy      = (state != IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            msg      <= '0;
            acc      <= '0;
            idx      <= '0;
            out_code <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        msg   <= in_msg;
                        acc   <= '0;
                        idx   <= '0;
                        state <= RUN;
                    end
                end
                RUN: begin
                    acc <= acc_next;
                    if (idx == IW'(N - 1)) begin
                        out_code <= acc_next;
                        idx      <= '0;
                        state    <= DONE;
                    end else begin
                        idx <= idx + IW'(1);
                    end
                end
                DONE: begin
                    if (out_ready)
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef GF2ENC_PARITY_EN
    // Parity is captured on the same edge as out_code so the two never disagree.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            out_par <= 1'b0;
        else if (state == RUN && idx == IW'(N - 1))
            out_par <= ^acc_next;
    end
`endif

endmodule
